// File: rtl/next_pc_unit.sv
// -----------------------------------------------------------------------------
// next_pc_unit
//
// Picks the next fetch PC each cycle. It combines a direct-mapped branch target
// buffer (BTB) lookup on the current fetch PC with the resolution of the
// control-flow instruction in EX. A wrong prediction in EX raises flush, and
// fetch is redirected to the correct path in the same cycle.
//
// Build option:
//   BTB_PREDICT_EN  defined   : BTB with per-entry valid/tag/target and a 2-bit
//                               saturating direction counter.
//                   undefined : no table storage. Fetch always predicts
//                               not-taken (pred_target = pc+4), so any taken
//                               resolution in EX flushes.
//
// Parameters:
//   ENTRIES         number of BTB entries (power of two, 2..64)
//
// Ports:
//   clk             clock, rising edge
//   reset           asynchronous, active-high; clears all valid bits and
//                   sets all counters to weakly-not-taken (2'b01)
//   pc              current fetch PC
//   ex_valid        EX holds a resolved control-flow instruction
//   ex_pc           PC of that instruction
//   ex_is_cond      1 = conditional branch, 0 = unconditional jump
//   ex_taken        actual direction
//   ex_target       actual target
//   ex_pred_taken   prediction that travelled with the instruction
//   ex_pred_target  predicted target that travelled with the instruction
//   pc_new          next PC for the PC register (valid every cycle)
//   pred_taken      prediction for pc, to be piped to EX
//   pred_target     predicted target for pc, to be piped to EX
//   flush           mispredict; squash IF/ID and ID/EX this cycle
// -----------------------------------------------------------------------------
module next_pc_unit #(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_cond,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic [31:0] pc_new,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        flush
);

  // Sequential fall-through addresses. They wrap modulo 2^32 naturally.
  logic [31:0] pc_plus4;
  logic [31:0] ex_pc_plus4;
  logic        mispredict;

  assign pc_plus4    = pc + 32'd4;
  assign ex_pc_plus4 = ex_pc + 32'd4;

  // A target mismatch matters only when the branch was actually taken. A
  // correctly predicted not-taken branch has a don't-care target.
  assign mispredict = ex_valid &
                      ((ex_taken != ex_pred_taken) |
                       (ex_taken & (ex_target != ex_pred_target)));

  // Redirects are suppressed while reset is held.
  assign flush = mispredict & ~reset;

`ifdef BTB_PREDICT_EN

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX - 2;

  // Flattened view of the table. Each element is driven by exactly one entry
  // in the generate loop below.
  logic [ENTRIES-1:0] valid_vec;
  logic [1:0]         ctr_arr    [ENTRIES];
  logic [TAG_W-1:0]   tag_arr    [ENTRIES];
  logic [31:0]        target_arr [ENTRIES];

  // Fetch-side lookup.
  logic [IDX-1:0]     rd_idx;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_hit;

  // EX-side lookup and update.
  logic [IDX-1:0]     wr_idx;
  logic [TAG_W-1:0]   wr_tag;
  logic               ex_hit;
  logic [1:0]         ex_ctr;
  logic [1:0]         ctr_next;
  logic               upd_en;
  logic               tgt_en;

  assign rd_idx = pc[IDX+1:2];
  assign rd_tag = pc[31:IDX+2];
  assign rd_hit = valid_vec[rd_idx] & (tag_arr[rd_idx] == rd_tag);

  // The lookup reads the registered table. An update to the same index in
  // the same cycle becomes visible only after the edge.
  assign pred_taken  = rd_hit & ctr_arr[rd_idx][1];
  assign pred_target = rd_hit ? target_arr[rd_idx] : pc_plus4;

  assign wr_idx = ex_pc[IDX+1:2];
  assign wr_tag = ex_pc[31:IDX+2];
  assign ex_hit = valid_vec[wr_idx] & (tag_arr[wr_idx] == wr_tag);
  assign ex_ctr = ctr_arr[wr_idx];

  // Counter value written back for the EX entry.
  //   hit  : saturating +/-1 on the actual direction
  //   miss : only taken resolutions allocate. A jump starts strongly taken
  //          and a conditional branch starts weakly taken.
  always_comb begin
    ctr_next = ex_is_cond ? 2'b10 : 2'b11;
    if (ex_hit) begin
      if (ex_taken) begin
        ctr_next = (ex_ctr == 2'b11) ? 2'b11 : ex_ctr + 2'd1;
      end else begin
        ctr_next = (ex_ctr == 2'b00) ? 2'b00 : ex_ctr - 2'd1;
      end
    end
  end

  // A not-taken miss leaves the table untouched.
  assign upd_en = ex_valid & (ex_hit | ex_taken);

  // Tag and target are written on every taken resolution. On a hit the tag
  // is rewritten with its own value, so a single enable covers both
  // allocation and target refresh.
  assign tgt_en = ex_valid & ex_taken;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [1:0]       ctr_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [31:0]      target_reg;
      logic             sel;

      assign sel = (wr_idx == IDX'(gi));

      // Valid and counter carry the prediction history and are cleared by
      // reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg <= 1'b0;
          ctr_reg   <= 2'b01;
        end else if (upd_en && sel) begin
          valid_reg <= 1'b1;
          ctr_reg   <= ctr_next;
        end
      end

      // Tag and target need no reset because valid gates them. The reset
      // term still blocks any write on an edge where reset is asserted.
      always_ff @(posedge clk) begin
        if (!reset && tgt_en && sel) begin
          tag_reg    <= wr_tag;
          target_reg <= ex_target;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign ctr_arr[gi]    = ctr_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
    end
  endgenerate

`else

  // Static not-taken prediction. No state exists, so clk and ex_is_cond have
  // no function in this build.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, clk, ex_is_cond};

  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus4;

`endif

  // Next-PC priority: the EX redirect wins, then the fetch prediction, then
  // the sequential fall-through.
  always_comb begin
    pc_new = pc_plus4;
    if (flush) begin
      pc_new = ex_taken ? ex_target : ex_pc_plus4;
    end else if (pred_taken) begin
      pc_new = pred_target;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_next_pc_unit
//
// Directed bench for next_pc_unit with ENTRIES=16. Expected values are
// hand-derived. Where the outcome depends on whether the BTB is built in, the
// expectation is chosen through the BTB constant below.
// -----------------------------------------------------------------------------
module tb_next_pc_unit;

`ifdef BTB_PREDICT_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_cond;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] pc_new;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;

  int tests_run = 0;
  int tests_failed = 0;

  next_pc_unit #(.ENTRIES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .ex_valid       (ex_valid),
    .ex_pc          (ex_pc),
    .ex_is_cond     (ex_is_cond),
    .ex_taken       (ex_taken),
    .ex_target      (ex_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .pc_new         (pc_new),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("[TB] %-16s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_ex(input logic v, input logic [31:0] epc, input logic cond,
                        input logic tkn, input logic [31:0] tgt,
                        input logic ptkn, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_pc          = epc;
    ex_is_cond     = cond;
    ex_taken       = tkn;
    ex_target      = tgt;
    ex_pred_taken  = ptkn;
    ex_pred_target = ptgt;
  endtask

  task automatic idle();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Advance past the next rising edge. Inputs change and outputs are checked
  // away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset is held with a taken resolution present. Flush must stay low,
    // and the edge under reset must not allocate.
    reset = 1'b1;
    pc    = 32'h100;
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
    #1;
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_pc_new", pc_new, 32'h104);
    check("rst_pred", 32'(pred_taken), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    #1;

    // After reset: pc=0x100 falls through.
    check("init_pc_new", pc_new, 32'h104);
    check("init_pred", 32'(pred_taken), 32'd0);
    check("init_pred_tgt", pred_target, 32'h104);
    check("init_flush", 32'(flush), 32'd0);

    // A taken conditional at 0x100 that was predicted not-taken.
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h104);
    #1;
    check("alloc_flush", 32'(flush), 32'd1);
    check("alloc_pc_new", pc_new, 32'h200);
    tick();
    idle();
    #1;
    check("trained_pred", 32'(pred_taken), 32'(BTB));
    check("trained_pc_new", pc_new, BTB ? 32'h200 : 32'h104);

    // First not-taken resolution. It flushes only if taken was predicted.
    // The same-cycle lookup must still see the old counter (10).
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, BTB, BTB ? 32'h200 : 32'h104);
    #1;
    check("nt1_flush", 32'(flush), 32'(BTB));
    check("nt1_pc_new", pc_new, 32'h104);
    check("nt1_war_pred", 32'(pred_taken), 32'(BTB));
    tick();
    idle();
    #1;
    check("nt1_after_pred", 32'(pred_taken), 32'd0);
    check("nt1_after_pcnew", pc_new, 32'h104);

    // Second not-taken resolution (01 -> 00). It was predicted not-taken.
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h104);
    #1;
    check("nt2_flush", 32'(flush), 32'd0);
    check("nt2_pc_new", pc_new, 32'h104);
    tick();
    // The third not-taken must saturate at 00.
    #1;
    check("nt3_flush", 32'(flush), 32'd0);
    tick();

    // Taken with a new target. Starting from a saturated 00 this gives 01,
    // which still predicts not-taken.
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0, 32'h104);
    #1;
    check("tk1_flush", 32'(flush), 32'd1);
    check("tk1_pc_new", pc_new, 32'h300);
    tick();
    idle();
    #1;
    check("tk1_after_pred", 32'(pred_taken), 32'd0);

    // A second taken gives 10, which predicts taken to the rewritten target.
    set_ex(1'b1, 32'h100, 1'b1, 1'b1, 32'h300, 1'b0, 32'h104);
    #1;
    check("tk2_flush", 32'(flush), 32'd1);
    tick();
    idle();
    #1;
    check("tk2_after_pred", 32'(pred_taken), 32'(BTB));
    check("tk2_after_tgt", pred_target, BTB ? 32'h300 : 32'h104);

    // Alias: a jump at 0x140 shares index 0 with 0x100 and replaces it.
    set_ex(1'b1, 32'h140, 1'b0, 1'b1, 32'h500, 1'b0, 32'h144);
    #1;
    check("alias_flush", 32'(flush), 32'd1);
    check("alias_pc_new", pc_new, 32'h500);
    tick();
    idle();
    #1;
    check("alias_100_pred", 32'(pred_taken), 32'd0);
    check("alias_100_pcnew", pc_new, 32'h104);
    pc = 32'h140;
    #1;
    check("alias_140_pred", 32'(pred_taken), 32'(BTB));
    check("alias_140_pcnew", pc_new, BTB ? 32'h500 : 32'h144);

    // The jump resolves exactly as predicted: no flush, and fetch follows
    // the BTB.
    set_ex(1'b1, 32'h140, 1'b0, 1'b1, 32'h500, BTB, BTB ? 32'h500 : 32'h144);
    #1;
    check("jok_flush", 32'(flush), BTB ? 32'd0 : 32'd1);
    check("jok_pc_new", pc_new, 32'h500);
    tick();

    // The jump is taken in the predicted direction but to a different target.
    set_ex(1'b1, 32'h140, 1'b0, 1'b1, 32'h600, BTB, BTB ? 32'h500 : 32'h144);
    #1;
    check("jtgt_flush", 32'(flush), 32'd1);
    check("jtgt_pc_new", pc_new, 32'h600);
    tick();
    idle();
    #1;
    check("jtgt_after_pred", 32'(pred_taken), 32'(BTB));
    check("jtgt_after_tgt", pred_target, BTB ? 32'h600 : 32'h144);

    // Wrap-around of +4 on both the fetch and EX paths.
    pc = 32'hFFFF_FFFC;
    #1;
    check("wrap_pc_new", pc_new, 32'h0);
    check("wrap_pred_tgt", pred_target, 32'h0);
    check("wrap_pred", 32'(pred_taken), 32'd0);
    set_ex(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h10, 1'b1, 32'h10);
    #1;
    check("wrap_ex_flush", 32'(flush), 32'd1);
    check("wrap_ex_pc_new", pc_new, 32'h0);
    tick();
    idle();
    #1;
    check("wrap_noalloc", 32'(pred_taken), 32'd0);

    // Mid-cycle reset pulse: all history is lost immediately.
    pc = 32'h140;
    #2;
    reset = 1'b1;
    #1;
    check("rst2_pred", 32'(pred_taken), 32'd0);
    check("rst2_pc_new", pc_new, 32'h144);
    reset = 1'b0;
    tick();
    check("rst2_140_pred", 32'(pred_taken), 32'd0);
    pc = 32'h100;
    #1;
    check("rst2_100_pred", 32'(pred_taken), 32'd0);
    check("rst2_100_pcnew", pc_new, 32'h104);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
